// File: rtl/sdio_irq_reg_if.sv
// Register-bus bundle between the SD host register decoder and the SD-clock register banks.
interface sdio_irq_reg_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          reg_data_wr;
  logic          reg_addr_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  modport master (
    output reg_data_wr,
    output reg_addr_wr,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_data_wr,
    input  reg_addr_wr,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/sdio_irq_reg.sv
// Parametrised interrupt status/enable bank with sticky sources, registered irq and
// multi-byte live-counter readback with an upper-byte snapshot taken on the low-byte read.
module sdio_irq_reg #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int NSRC     = 12,
  parameter int STS_BASE = 32,
  parameter int NCNT     = 2,
  parameter int CNT_W    = 16,
  parameter int CNT_BASE = 134,
  parameter int RC       = 0
) (
  input  logic                  sd_clk,
  input  logic                  rstn,
  sdio_irq_reg_if.slave         bus,
  input  logic [NSRC-1:0]       evt,
  input  logic [NCNT*CNT_W-1:0] cnt_in,
  output logic [NSRC-1:0]       irq_sts,
  output logic [NSRC-1:0]       irq_en,
  output logic                  irq
);

  localparam int NSB  = (NSRC + DW - 1) / DW;
  localparam int NCB  = CNT_W / DW;
  localparam int PADW = NSB * DW;

  logic [NSRC-1:0]  sts_r;
  logic [NSRC-1:0]  en_r;
  logic             irq_r;
  logic [DW-1:0]    rdata_r;
  logic [CNT_W-1:0] snap_r [NCNT];

  logic [NSB-1:0]   sts_hit_s;
  logic [NSB-1:0]   en_hit_s;
  logic [NCNT-1:0]  cnt_lo_hit_s;
  logic [NSRC-1:0]  clr_s;
  logic [NSRC-1:0]  en_nxt_s;
  logic [PADW-1:0]  sts_pad_s;
  logic [PADW-1:0]  en_pad_s;
  logic [DW-1:0]    rd_val_s;

  assign sts_pad_s = PADW'(sts_r);
  assign en_pad_s  = PADW'(en_r);

  // Address decode for status, enable and counter low-byte locations.
  always_comb begin
    sts_hit_s    = {NSB{1'b0}};
    en_hit_s     = {NSB{1'b0}};
    cnt_lo_hit_s = {NCNT{1'b0}};
    for (int k = 0; k < NSB; k++) begin
      sts_hit_s[k] = (bus.reg_addr == AW'(STS_BASE + k));
      en_hit_s[k]  = (bus.reg_addr == AW'(STS_BASE + NSB + k));
    end
    for (int j = 0; j < NCNT; j++) begin
      cnt_lo_hit_s[j] = (bus.reg_addr == AW'(CNT_BASE + j * NCB));
    end
  end

  // Per-source clear mask and enable next-state; read-to-clear clears exactly what was returned.
  always_comb begin
    clr_s    = {NSRC{1'b0}};
    en_nxt_s = en_r;
    for (int i = 0; i < NSRC; i++) begin
      if (RC != 0) begin
        clr_s[i] = bus.reg_addr_wr & sts_hit_s[i / DW] & sts_r[i];
      end else begin
        clr_s[i] = bus.reg_data_wr & sts_hit_s[i / DW] & bus.reg_wdata[i % DW];
      end
      if (bus.reg_data_wr && en_hit_s[i / DW]) begin
        en_nxt_s[i] = bus.reg_wdata[i % DW];
      end else begin
        en_nxt_s[i] = en_r[i];
      end
    end
  end

  // Read mux over the whole map; unmapped addresses fall through to zero.
  always_comb begin
    rd_val_s = {DW{1'b0}};
    for (int k = 0; k < NSB; k++) begin
      rd_val_s = rd_val_s
               | (sts_hit_s[k] ? sts_pad_s[k*DW +: DW] : {DW{1'b0}})
               | (en_hit_s[k]  ? en_pad_s[k*DW +: DW]  : {DW{1'b0}});
    end
    for (int j = 0; j < NCNT; j++) begin
      for (int b = 0; b < NCB; b++) begin
        rd_val_s = rd_val_s
                 | ((bus.reg_addr == AW'(CNT_BASE + j * NCB + b))
                    ? ((b == 0) ? cnt_in[j*CNT_W + b*DW +: DW] : snap_r[j][b*DW +: DW])
                    : {DW{1'b0}});
      end
    end
  end

  // Sticky status (set wins over clear), enables and the registered interrupt.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      sts_r <= {NSRC{1'b0}};
      en_r  <= {NSRC{1'b0}};
      irq_r <= 1'b0;
    end else begin
      sts_r <= (sts_r & ~clr_s) | evt;
      en_r  <= en_nxt_s;
      irq_r <= |(sts_r & en_r);
    end
  end

  // Registered read data; holds between read strobes.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r <= {DW{1'b0}};
    end else if (bus.reg_addr_wr) begin
      rdata_r <= rd_val_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Counter snapshots, captured only by a read of that counter's low byte.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < NCNT; j++) begin
        snap_r[j] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NCNT; j++) begin
        if (bus.reg_addr_wr && cnt_lo_hit_s[j]) begin
          snap_r[j] <= cnt_in[j*CNT_W +: CNT_W];
        end else begin
          snap_r[j] <= snap_r[j];
        end
      end
    end
  end

  assign bus.reg_rdata = rdata_r;
  assign irq_sts       = sts_r;
  assign irq_en        = en_r;
  assign irq           = irq_r;

endmodule
